text_cursor_ctrl: RTL and testbench

TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

---
 rtl/text_cursor_ctrl.sv | 129 ++++++++++++
 tb/tb_text_cursor_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_ctrl.sv
// Text-terminal cursor controller: turns UART bytes into character-RAM writes,
// tracks the cursor, and sweeps the screen to BLANK on form feed.
module text_cursor_ctrl #(
  parameter int          COLS  = 32,
  parameter int          ROWS  = 4,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       wr_en,
  output logic [1:0] wr_row,
  output logic [4:0] wr_col,
  output logic [7:0] wr_data,
  output logic [1:0] cur_row,
  output logic [4:0] cur_col,
  output logic       busy
);

  localparam logic [4:0] COL_MAX = 5'(COLS - 1);
  localparam logic [1:0] ROW_MAX = 2'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t     state;
  logic       accept;
  logic       printable;
  logic [1:0] bs_row;
  logic [4:0] bs_col;

  // Row-major step with wrap; masking keeps unused high bits at zero.
  function automatic logic [6:0] next_pos(input logic [1:0] r, input logic [4:0] c);
    if (c == COL_MAX) return {(r + 2'd1) & ROW_MAX, 5'd0};
    else              return {r, c + 5'd1};
  endfunction

  assign accept    = rx_valid && rx_ready;
  assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bs_row = cur_row;
    bs_col = cur_col;
    if (cur_col != 5'd0) begin
      bs_col = cur_col - 5'd1;
    end else if (cur_row != 2'd0) begin
      bs_row = cur_row - 2'd1;
      bs_col = COL_MAX;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rx_ready <= 1'b1;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      wr_row   <= 2'd0;
      wr_col   <= 5'd0;
      wr_data  <= 8'd0;
      cur_row  <= 2'd0;
      cur_col  <= 5'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              wr_en              <= 1'b1;
              wr_row             <= cur_row;
              wr_col             <= cur_col;
              wr_data            <= rx_data;
              {cur_row, cur_col} <= next_pos(cur_row, cur_col);
            end else if (rx_data == CH_CR || rx_data == CH_LF) begin
              cur_col <= 5'd0;
              cur_row <= (cur_row + 2'd1) & ROW_MAX;
            end else if (rx_data == CH_BS) begin
              wr_en   <= 1'b1;
              wr_row  <= bs_row;
              wr_col  <= bs_col;
              wr_data <= BLANK;
              cur_row <= bs_row;
              cur_col <= bs_col;
            end else if (rx_data == CH_FF) begin
              state    <= CLEAR;
              rx_ready <= 1'b0;
              busy     <= 1'b1;
              wr_en    <= 1'b1;
              wr_row   <= 2'd0;
              wr_col   <= 5'd0;
              wr_data  <= BLANK;
            end
          end
        end
        CLEAR: begin
          // The write address doubles as the sweep counter.
          if (wr_row == ROW_MAX && wr_col == COL_MAX) begin
            state   <= DONE;
            busy    <= 1'b0;
            cur_row <= 2'd0;
            cur_col <= 5'd0;
          end else begin
            wr_en            <= 1'b1;
            {wr_row, wr_col} <= next_pos(wr_row, wr_col);
          end
        end
        DONE: begin
          state    <= IDLE;
          rx_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed self-checking bench for text_cursor_ctrl at default parameters.
module tb_text_cursor_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_data;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;

  int errors = 0;
  int checks = 0;

  text_cursor_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge; after return the outputs of cycle N+1 are visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // {wr_en, wr_row, wr_col, wr_data}
  function automatic logic [31:0] wr_vec();
    return {16'd0, wr_en, wr_row, wr_col, wr_data};
  endfunction

  function automatic logic [31:0] cur_vec();
    return {25'd0, cur_row, cur_col};
  endfunction

  logic [6:0] idx;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();

    // Reset state
    check("reset_wr", wr_vec(), 32'd0);
    check("reset_cur", cur_vec(), 32'd0);
    check("reset_ready_busy", {rx_ready, busy}, 2'b10);

    // 'A' at (0,0)
    send(8'h41);
    check("A_write", wr_vec(), {1'b1, 2'd0, 5'd0, 8'h41});
    check("A_cur", cur_vec(), {2'd0, 5'd1});
    @(negedge clk);
    check("A_pulse_single", wr_en, 1'b0);

    // Reset and a byte in the same cycle: reset wins
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h51;
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("rst_prio_wr", wr_en, 1'b0);
    check("rst_prio_cur", cur_vec(), 32'd0);

    // Ignored bytes: no write, no cursor move
    send(8'h42);
    send(8'h7F);
    check("del_ignored", {wr_en, cur_row, cur_col}, {1'b0, 2'd0, 5'd1});
    send(8'h01);
    check("ctl_ignored", {wr_en, cur_row, cur_col}, {1'b0, 2'd0, 5'd1});
    send(8'hC3);
    check("hi_ignored", {wr_en, cur_row, cur_col}, {1'b0, 2'd0, 5'd1});

    // Row wrap after 33 bytes, screen wrap at (3,31)
    do_reset();
    for (int i = 0; i < 32; i++) send(8'h61);
    check("32_cur", cur_vec(), {2'd1, 5'd0});
    send(8'h62);
    check("33_write", wr_vec(), {1'b1, 2'd1, 5'd0, 8'h62});
    check("33_cur", cur_vec(), {2'd1, 5'd1});
    for (int i = 0; i < 94; i++) send(8'h7E);
    check("at_3_31", cur_vec(), {2'd3, 5'd31});
    send(8'h20);
    check("last_write", wr_vec(), {1'b1, 2'd3, 5'd31, 8'h20});
    check("screen_wrap", cur_vec(), 32'd0);

    // CR / LF from (2,5)
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h30);
    check("at_2_5", cur_vec(), {2'd2, 5'd5});
    send(8'h0D);
    check("cr_no_write", wr_en, 1'b0);
    check("cr_cur", cur_vec(), {2'd3, 5'd0});
    send(8'h0A);
    check("lf_wrap_cur", cur_vec(), 32'd0);

    // BS across a row boundary, then BS at home
    send(8'h0A);
    check("at_1_0", cur_vec(), {2'd1, 5'd0});
    send(8'h08);
    check("bs_write", wr_vec(), {1'b1, 2'd0, 5'd31, 8'h20});
    check("bs_cur", cur_vec(), {2'd0, 5'd31});
    send(8'h08);
    check("bs_mid_write", wr_vec(), {1'b1, 2'd0, 5'd30, 8'h20});
    do_reset();
    send(8'h08);
    check("bs_home_write", wr_vec(), {1'b1, 2'd0, 5'd0, 8'h20});
    check("bs_home_cur", cur_vec(), 32'd0);

    // Full clear sweep from (2,7), with a byte offered mid-sweep
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h2E);
    check("at_2_7", cur_vec(), {2'd2, 5'd7});
    send(8'h0C);
    for (int i = 0; i < 128; i++) begin
      idx = 7'(i);
      // {wr_en, row, col, data, rx_ready, busy, cur_row, cur_col}
      check($sformatf("sweep_%0d", i),
            {7'd0, wr_en, wr_row, wr_col, wr_data, rx_ready, busy, cur_row, cur_col},
            {7'd0, 1'b1, idx[6:5], idx[4:0], 8'h20, 1'b0, 1'b1, 2'd2, 5'd7});
      rx_valid = (i == 10);
      rx_data  = 8'h5A;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("done_state", {wr_en, rx_ready, busy, cur_row, cur_col}, {1'b0, 1'b0, 1'b0, 2'd0, 5'd0});
    @(negedge clk);
    check("idle_after_done", {wr_en, rx_ready}, 2'b01);
    send(8'h42);
    check("post_clear_write", wr_vec(), {1'b1, 2'd0, 5'd0, 8'h42});

    // Reset aborts a sweep at cycle 40
    send(8'h0C);
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("sweep40_addr", wr_vec(), {1'b1, 2'd1, 5'd8, 8'h20});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_wr", wr_en, 1'b0);
    check("abort_cur", cur_vec(), 32'd0);
    check("abort_ready_busy", {rx_ready, busy}, 2'b10);
    @(negedge clk);
    check("abort_no_more_wr", wr_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
